// File: rtl/pool_pkg.sv
// ---------------------------------------------------------------------------
// pool_pkg
// Shared definitions for the streaming pooling engine:
//   - pool_state_e : controller state encoding (also exported for debug)
//   - KSEL_*       : kernel_sel encodings (K = 1, 2, 4, 1)
//   - MODE_*       : reduction mode constants (average / max)
//   - log2k()      : maps kernel_sel to log2(K)
// ---------------------------------------------------------------------------
package pool_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_EMIT  = 2'd2,
        ST_DONE  = 2'd3
    } pool_state_e;

    localparam logic [1:0] KSEL_K1     = 2'd0;
    localparam logic [1:0] KSEL_K2     = 2'd1;
    localparam logic [1:0] KSEL_K4     = 2'd2;
    localparam logic [1:0] KSEL_K1_ALT = 2'd3;

    localparam logic MODE_AVG = 1'b0;
    localparam logic MODE_MAX = 1'b1;

    // log2 of the kernel size selected by kernel_sel (0, 1 or 2).
    function automatic logic [1:0] log2k(input logic [1:0] kernel_sel);
        logic [1:0] r;
        case (kernel_sel)
            KSEL_K1:     r = 2'd0;
            KSEL_K2:     r = 2'd1;
            KSEL_K4:     r = 2'd2;
            KSEL_K1_ALT: r = 2'd0;
            default:     r = 2'd0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/pool_window_reduce.sv
// ---------------------------------------------------------------------------
// pool_window_reduce
// Accumulator for one pooling window. Each accumulate pulse folds up to four
// lane values (only the first K are used) into a running sum or running max.
// Masked lanes contribute zero.
//
// Ports:
//   clk, reset      clock, asynchronous active-low reset
//   clear           zero the accumulator (priority over accum)
//   accum           fold lane_vals/lane_mask into the accumulator
//   mode            MODE_AVG or MODE_MAX
//   log2k_sel       log2 of the kernel size
//   lane_vals       four DWIDTH lane values, lane t at [t*DWIDTH +: DWIDTH]
//   lane_mask       per-lane valid bits
//   result          average (sum >> 2*log2K, truncated) or max
// ---------------------------------------------------------------------------
module pool_window_reduce
    import pool_pkg::*;
#(
    parameter int DWIDTH = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                accum,
    input  logic                mode,
    input  logic [1:0]          log2k_sel,
    input  logic [4*DWIDTH-1:0] lane_vals,
    input  logic [3:0]          lane_mask,
    output logic [DWIDTH-1:0]   result
);

    // Four extra bits hold a sum of up to 16 full-scale terms.
    localparam int AW = DWIDTH + 4;

    logic [AW-1:0]     acc_q;
    logic [AW-1:0]     acc_d;
    logic [AW-1:0]     sum_v;
    logic [AW-1:0]     max_v;
    logic [AW-1:0]     term;
    logic [3:0]        lane_used;
    logic [DWIDTH-1:0] avg_v;

    always_comb begin
        case (log2k_sel)
            2'd1:    lane_used = 4'b0011;
            2'd2:    lane_used = 4'b1111;
            default: lane_used = 4'b0001;
        endcase

        sum_v = acc_q;
        max_v = acc_q;
        term  = '0;
        for (int t = 0; t < 4; t++) begin
            term = (lane_mask[t] && lane_used[t]) ? AW'(lane_vals[t*DWIDTH +: DWIDTH]) : '0;
            sum_v = sum_v + term;
            if (term > max_v) begin
                max_v = term;
            end
        end

        acc_d = acc_q;
        if (clear) begin
            acc_d = '0;
        end else if (accum) begin
            acc_d = (mode == MODE_MAX) ? max_v : sum_v;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    // Divisor is K*K regardless of how many lanes were masked.
    always_comb begin
        avg_v  = DWIDTH'(acc_q >> {log2k_sel, 1'b0});
        result = (mode == MODE_MAX) ? acc_q[DWIDTH-1:0] : avg_v;
    end

endmodule

// File: rtl/pool_stream.sv
// ---------------------------------------------------------------------------
// pool_stream
// Streaming KxK pooling engine (K = 1, 2, 4) with average or max reduction,
// valid/ready on both sides, and a combinational bypass when pooling is off.
//
// Handshake: a row transfers on in_valid && in_ready at a rising clock edge;
// a result transfers on out_valid && out_ready. A producer holding valid keeps
// its data stable until accepted; out_data/out_mask stay stable while
// out_valid is high and out_ready is low.
//
// Ports:
//   clk, reset          clock, asynchronous active-low reset
//   enable_pool         1 = pooling, 0 = combinational bypass
//   start               begins a job from IDLE
//   pool_mode           0 = average, 1 = max (latched at start)
//   kernel_sel          0/3 -> K=1, 1 -> K=2, 2 -> K=4 (latched at start)
//   num_out_rows        output rows per job, 0 treated as 1 (latched at start)
//   in_valid/in_ready   input row handshake
//   in_data/in_mask     input row vector and lane valid bits
//   out_valid/out_ready result row handshake
//   out_data/out_mask   result lanes 0..LANES/K-1, upper lanes zero
//   done_pool           one-cycle pulse after the final result handshake
//   dbg_state           current controller state
// ---------------------------------------------------------------------------
module pool_stream
    import pool_pkg::*;
#(
    parameter int DWIDTH = 8,
    parameter int LANES  = 16,
    parameter int ROWS_W = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable_pool,
    input  logic                    start,
    input  logic                    pool_mode,
    input  logic [1:0]              kernel_sel,
    input  logic [ROWS_W-1:0]       num_out_rows,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*DWIDTH-1:0] in_data,
    input  logic [LANES-1:0]        in_mask,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*DWIDTH-1:0] out_data,
    output logic [LANES-1:0]        out_mask,
    output logic                    done_pool,
    output logic [1:0]              dbg_state
);

    pool_state_e       state_q, state_d;
    logic              mode_q, mode_d;
    logic [1:0]        log2k_q, log2k_d;
    logic [ROWS_W-1:0] rows_left_q, rows_left_d;
    logic [1:0]        row_cnt_q, row_cnt_d;

    logic                    clear_acc;
    logic                    accept;
    logic                    row_last;
    logic [LANES-1:0]        win_active;
    logic [LANES*DWIDTH-1:0] pool_data;

    // Windows beyond LANES/K have no lanes for this kernel size.
    always_comb begin
        win_active = '0;
        for (int j = 0; j < LANES; j++) begin
            win_active[j] = (j < (LANES >> log2k_q));
        end
    end

    always_comb begin
        case (log2k_q)
            2'd1:    row_last = (row_cnt_q == 2'd1);
            2'd2:    row_last = (row_cnt_q == 2'd3);
            default: row_last = (row_cnt_q == 2'd0);
        endcase
    end

    // ---------------- controller ----------------
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        log2k_d     = log2k_q;
        rows_left_d = rows_left_q;
        row_cnt_d   = row_cnt_q;
        clear_acc   = 1'b0;
        accept      = 1'b0;

        if (!enable_pool) begin
            // Bypass discards any partial window.
            state_d   = ST_IDLE;
            row_cnt_d = '0;
            clear_acc = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d     = ST_ACCUM;
                        mode_d      = pool_mode;
                        log2k_d     = log2k(kernel_sel);
                        rows_left_d = (num_out_rows == '0) ? ROWS_W'(1) : num_out_rows;
                        row_cnt_d   = '0;
                        clear_acc   = 1'b1;
                    end
                end
                ST_ACCUM: begin
                    if (in_valid) begin
                        accept = 1'b1;
                        if (row_last) begin
                            state_d   = ST_EMIT;
                            row_cnt_d = '0;
                        end else begin
                            row_cnt_d = row_cnt_q + 2'd1;
                        end
                    end
                end
                ST_EMIT: begin
                    if (out_ready) begin
                        if (rows_left_q <= ROWS_W'(1)) begin
                            state_d     = ST_DONE;
                            rows_left_d = '0;
                        end else begin
                            state_d     = ST_ACCUM;
                            rows_left_d = rows_left_q - ROWS_W'(1);
                            clear_acc   = 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            mode_q      <= MODE_AVG;
            log2k_q     <= '0;
            rows_left_q <= '0;
            row_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            log2k_q     <= log2k_d;
            rows_left_q <= rows_left_d;
            row_cnt_q   <= row_cnt_d;
        end
    end

    // ---------------- window datapath ----------------
    for (genvar j = 0; j < LANES; j++) begin : g_win
        localparam bit HAS_K2 = ((2*j + 1) < LANES);
        localparam bit HAS_K4 = ((4*j + 3) < LANES);
        localparam int B2     = HAS_K2 ? 2*j : 0;
        localparam int B4     = HAS_K4 ? 4*j : 0;

        logic [4*DWIDTH-1:0] vals;
        logic [3:0]          msk;
        logic [DWIDTH-1:0]   res;

        always_comb begin
            vals = '0;
            msk  = '0;
            case (log2k_q)
                2'd1: begin
                    if (HAS_K2) begin
                        vals[2*DWIDTH-1:0] = in_data[B2*DWIDTH +: 2*DWIDTH];
                        msk[1:0]           = in_mask[B2 +: 2];
                    end
                end
                2'd2: begin
                    if (HAS_K4) begin
                        vals = in_data[B4*DWIDTH +: 4*DWIDTH];
                        msk  = in_mask[B4 +: 4];
                    end
                end
                default: begin
                    vals[DWIDTH-1:0] = in_data[j*DWIDTH +: DWIDTH];
                    msk[0]           = in_mask[j];
                end
            endcase
        end

        pool_window_reduce #(
            .DWIDTH(DWIDTH)
        ) u_reduce (
            .clk       (clk),
            .reset     (reset),
            .clear     (clear_acc || !win_active[j]),
            .accum     (accept && win_active[j]),
            .mode      (mode_q),
            .log2k_sel (log2k_q),
            .lane_vals (vals),
            .lane_mask (msk),
            .result    (res)
        );

        assign pool_data[j*DWIDTH +: DWIDTH] = win_active[j] ? res : '0;
    end

    // ---------------- output mux ----------------
    // Accumulators are frozen during EMIT, so the result is stable without
    // a separate output register.
    always_comb begin
        if (enable_pool) begin
            in_ready  = (state_q == ST_ACCUM);
            out_valid = (state_q == ST_EMIT);
            out_data  = (state_q == ST_EMIT) ? pool_data : '0;
            out_mask  = (state_q == ST_EMIT) ? win_active : '0;
            done_pool = (state_q == ST_DONE);
        end else begin
            in_ready  = out_ready;
            out_valid = in_valid;
            out_data  = in_data;
            out_mask  = in_mask;
            done_pool = 1'b0;
        end
    end

    assign dbg_state = state_q;

endmodule

// File: tb/tb_pool_stream.sv
module tb_pool_stream;

    localparam int DWIDTH = 8;
    localparam int LANES  = 16;
    localparam int ROWS_W = 8;
    localparam int W      = LANES * DWIDTH;

    logic              clk;
    logic              reset;
    logic              enable_pool;
    logic              start;
    logic              pool_mode;
    logic [1:0]        kernel_sel;
    logic [ROWS_W-1:0] num_out_rows;
    logic              in_valid;
    logic              in_ready;
    logic [W-1:0]      in_data;
    logic [LANES-1:0]  in_mask;
    logic              out_valid;
    logic              out_ready;
    logic [W-1:0]      out_data;
    logic [LANES-1:0]  out_mask;
    logic              done_pool;
    logic [1:0]        dbg_state;

    int checks = 0;
    int errors = 0;

    pool_stream #(
        .DWIDTH(DWIDTH),
        .LANES (LANES),
        .ROWS_W(ROWS_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable_pool (enable_pool),
        .start       (start),
        .pool_mode   (pool_mode),
        .kernel_sel  (kernel_sel),
        .num_out_rows(num_out_rows),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_mask     (in_mask),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_mask    (out_mask),
        .done_pool   (done_pool),
        .dbg_state   (dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [W-1:0]     exp_q[$];
    logic [LANES-1:0] exp_mask_q[$];
    logic [W-1:0]     rows_d[$];
    logic [LANES-1:0] rows_m[$];
    bit               m_busy;
    bit               m_done;
    bit               m_mode;
    int               m_k;
    int               m_rows_left;

    function automatic int k_of(input logic [1:0] ks);
        if (ks == 2'd1) return 2;
        if (ks == 2'd2) return 4;
        return 1;
    endfunction

    function automatic logic [W-1:0] fill(input logic [7:0] v);
        logic [W-1:0] r;
        for (int i = 0; i < LANES; i++) r[i*DWIDTH +: DWIDTH] = v;
        return r;
    endfunction

    // One result row from the K buffered input rows.
    task automatic model_emit();
        logic [W-1:0]     d;
        logic [LANES-1:0] m;
        logic [W-1:0]     rowv;
        logic [LANES-1:0] rowm;
        int s, mx, v, lane;
        d = '0;
        m = '0;
        for (int j = 0; j < LANES / m_k; j++) begin
            s  = 0;
            mx = 0;
            for (int r = 0; r < m_k; r++) begin
                rowv = rows_d[r];
                rowm = rows_m[r];
                for (int t = 0; t < m_k; t++) begin
                    lane = j * m_k + t;
                    v = rowm[lane] ? int'(rowv[lane*DWIDTH +: DWIDTH]) : 0;
                    s += v;
                    if (v > mx) mx = v;
                end
            end
            d[j*DWIDTH +: DWIDTH] = DWIDTH'(m_mode ? mx : s / (m_k * m_k));
            m[j] = 1'b1;
        end
        exp_q.push_back(d);
        exp_mask_q.push_back(m);
    endtask

    task automatic model_clear();
        exp_q.delete();
        exp_mask_q.delete();
        rows_d.delete();
        rows_m.delete();
        m_busy = 0;
        m_done = 0;
    endtask

    // ---------------- compare process (1 time unit before each rising edge) ----------------
    always @(negedge clk) begin
        bit done_now, acc_now, pop_now;
        #4;
        if (!reset) begin
            model_clear();
        end else if (!enable_pool) begin
            check("byp_data", out_data, in_data);
            check("byp_mask", W'(out_mask), W'(in_mask));
            check("byp_valid", W'(out_valid), W'(in_valid));
            check("byp_ready", W'(in_ready), W'(out_ready));
            check("byp_done", W'(done_pool), '0);
            model_clear();
        end else begin
            check("done_pool", W'(done_pool), W'(m_done));
            check("out_valid", W'(out_valid), W'(exp_q.size() != 0));
            check("in_ready", W'(in_ready), W'(m_busy && exp_q.size() == 0));
            if (exp_q.size() != 0) begin
                check("out_data", out_data, exp_q[0]);
                check("out_mask", W'(out_mask), W'(exp_mask_q[0]));
            end
            done_now = m_done;
            acc_now  = m_busy && exp_q.size() == 0 && in_valid;
            pop_now  = exp_q.size() != 0 && out_ready;
            m_done   = 0;
            if (acc_now) begin
                rows_d.push_back(in_data);
                rows_m.push_back(in_mask);
                if (rows_d.size() == m_k) begin
                    model_emit();
                    rows_d.delete();
                    rows_m.delete();
                end
            end
            if (pop_now) begin
                void'(exp_q.pop_front());
                void'(exp_mask_q.pop_front());
                m_rows_left--;
                if (m_rows_left == 0) begin
                    m_busy = 0;
                    m_done = 1;
                end
            end
            if (start && !m_busy && !done_now) begin
                m_busy      = 1;
                m_mode      = pool_mode;
                m_k         = k_of(kernel_sel);
                m_rows_left = (num_out_rows == 0) ? 1 : int'(num_out_rows);
            end
        end
    end

    // ---------------- driver tasks (called on a falling edge) ----------------
    task automatic start_job(input bit mode, input logic [1:0] ks, input logic [ROWS_W-1:0] rows);
        start        = 1'b1;
        pool_mode    = mode;
        kernel_sel   = ks;
        num_out_rows = rows;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_row(input logic [W-1:0] d, input logic [LANES-1:0] m);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_mask  = m;
        #1;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL in_ready_wait: got in_ready=0 for %0d cycles required 1", n);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string name, output int cycles);
        cycles = -1;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            #1;
            if (done_pool) begin
                cycles = n;
                break;
            end
        end
        checks++;
        if (cycles < 0) begin
            errors++;
            $display("FAIL %s: got no done_pool within 400 cycles required a pulse", name);
        end
        @(negedge clk);
    endtask

    function automatic logic [W-1:0] rand_row();
        logic [W-1:0] r;
        for (int i = 0; i < LANES; i++) r[i*DWIDTH +: DWIDTH] = DWIDTH'($urandom_range(0, 255));
        return r;
    endfunction

    // ---------------- stimulus ----------------
    bit rand_on;

    initial begin
        logic [W-1:0] row;
        logic [W-1:0] snap;
        int cyc;
        int k, nrows;

        reset        = 1'b0;
        enable_pool  = 1'b1;
        start        = 1'b0;
        pool_mode    = 1'b0;
        kernel_sel   = 2'd0;
        num_out_rows = '0;
        in_valid     = 1'b0;
        in_data      = '0;
        in_mask      = '0;
        out_ready    = 1'b1;
        rand_on      = 0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_out_valid", W'(out_valid), '0);
        check("rst_in_ready", W'(in_ready), '0);
        check("rst_out_data", out_data, '0);
        check("rst_out_mask", W'(out_mask), '0);
        check("rst_done", W'(done_pool), '0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_state_idle", W'(dbg_state), '0);
        @(negedge clk);

        // K=2 average, 10 and 20 -> 15
        start_job(1'b0, 2'd1, 8'd1);
        send_row(fill(8'd10), '1);
        send_row(fill(8'd20), '1);
        #1;
        check("t1_valid", W'(out_valid), W'(1));
        check("t1_data", out_data, 128'h0000_0000_0000_0000_0F0F_0F0F_0F0F_0F0F);
        check("t1_mask", W'(out_mask), W'(16'h00FF));
        wait_done("t1_done", cyc);
        check("t1_done_latency", W'(cyc), '0);

        // K=4 max
        start_job(1'b1, 2'd2, 8'd1);
        for (int r = 0; r < 4; r++) begin
            for (int l = 0; l < LANES; l++) row[l*DWIDTH +: DWIDTH] = DWIDTH'(r * 16 + l);
            if (r == 3) row[5*DWIDTH +: DWIDTH] = 8'd255;
            send_row(row, '1);
        end
        #1;
        check("t2_lane0", W'(out_data[7:0]), W'(51));
        check("t2_lane1", W'(out_data[15:8]), W'(255));
        check("t2_lane2", W'(out_data[23:16]), W'(59));
        check("t2_lane3", W'(out_data[31:24]), W'(63));
        check("t2_upper", W'(out_data[W-1:32]), '0);
        check("t2_mask", W'(out_mask), W'(16'h000F));
        wait_done("t2_done", cyc);

        // Masking: lane 0 masked on the first row only -> (0+40+40+40)/4 = 30
        start_job(1'b0, 2'd1, 8'd1);
        send_row(fill(8'd40), 16'hFFFE);
        send_row(fill(8'd40), 16'hFFFF);
        #1;
        check("t3_data", out_data, 128'h0000_0000_0000_0000_2828_2828_2828_281E);
        check("t3_mask", W'(out_mask), W'(16'h00FF));
        wait_done("t3_done", cyc);

        // Back-pressure with two output rows
        out_ready = 1'b0;
        start_job(1'b0, 2'd1, 8'd2);
        send_row(fill(8'd10), '1);
        send_row(fill(8'd30), '1);
        in_valid = 1'b1;
        in_data  = fill(8'd50);
        in_mask  = '1;
        #1;
        snap = out_data;
        check("t4_first", out_data, 128'h0000_0000_0000_0000_1414_1414_1414_1414);
        for (int i = 0; i < 5; i++) begin
            check("t4_hold_ready", W'(in_ready), '0);
            check("t4_hold_valid", W'(out_valid), W'(1));
            check("t4_hold_data", out_data, snap);
            check("t4_hold_done", W'(done_pool), '0);
            @(negedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        #1;
        check("t4_no_early_done", W'(done_pool), '0);
        send_row(fill(8'd50), '1);
        send_row(fill(8'd70), '1);
        #1;
        check("t4_second", out_data, 128'h0000_0000_0000_0000_3C3C_3C3C_3C3C_3C3C);
        wait_done("t4_done", cyc);

        // Bypass and abort
        start_job(1'b0, 2'd2, 8'd1);
        send_row(fill(8'd99), '1);
        enable_pool = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = rand_row();
            in_mask   = 16'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            #1;
            check("t5_pass_data", out_data, in_data);
            check("t5_pass_ready", W'(in_ready), W'(out_ready));
            @(negedge clk);
        end
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        enable_pool = 1'b1;
        @(negedge clk);
        start_job(1'b0, 2'd2, 8'd1);
        for (int r = 0; r < 4; r++) send_row(fill(8'd8), '1);
        #1;
        check("t5_fresh", out_data, 128'h0000_0000_0000_0000_0000_0000_0808_0808);
        check("t5_mask", W'(out_mask), W'(16'h000F));
        wait_done("t5_done", cyc);

        // Async reset during EMIT
        out_ready = 1'b0;
        start_job(1'b1, 2'd3, 8'd1);
        send_row(rand_row(), 16'hF0F0);
        #1;
        check("t6_in_emit", W'(out_valid), W'(1));
        #1;
        reset = 1'b0;
        #1;
        check("t6_rst_valid", W'(out_valid), '0);
        check("t6_rst_data", out_data, '0);
        check("t6_rst_mask", W'(out_mask), '0);
        check("t6_rst_ready", W'(in_ready), '0);
        check("t6_rst_done", W'(done_pool), '0);
        @(negedge clk);
        @(negedge clk);
        reset     = 1'b1;
        out_ready = 1'b1;
        #1;
        check("t6_idle", W'(dbg_state), '0);
        @(negedge clk);
        #1;
        check("t6_no_output", W'(out_valid), '0);
        @(negedge clk);

        // Randomized jobs with random back-pressure and input gaps
        rand_on = 1;
        fork
            begin
                while (rand_on) begin
                    @(negedge clk);
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join_none
        for (int job = 0; job < 30; job++) begin
            logic       mode;
            logic [1:0] ks;
            logic [7:0] rows;
            mode  = 1'($urandom_range(0, 1));
            ks    = 2'($urandom_range(0, 3));
            rows  = 8'($urandom_range(0, 3));
            k     = k_of(ks);
            nrows = ((rows == 0) ? 1 : int'(rows)) * k;
            start_job(mode, ks, rows);
            for (int r = 0; r < nrows; r++) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                send_row(rand_row(), ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'hFFFF);
            end
            wait_done("rand_done", cyc);
        end
        rand_on = 0;
        repeat (3) @(negedge clk);
        out_ready = 1'b1;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pool_stream.md
# pool_stream

Streaming 2-D pooling engine that replaces the single-cycle, horizontal-only pooling stage on the systolic array output path. It reduces K×K windows, where K is 1, 2 or 4: K adjacent lanes within a row, across K consecutive input rows. Each window is reduced by average or max. A valid/ready handshake on both sides allows back-pressure toward the output write-back logic. When pooling is disabled the block is a transparent bypass.

## Interface
- DWIDTH, 8: element width, unsigned.
- LANES, 16: elements per row vector; power of two, ≥4.
- ROWS_W, 8: width of the output-row count.

- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- enable_pool  in  1  1 = pooling path, 0 = bypass.
- start  in  1  pulse; begins a job from IDLE.
- pool_mode  in  1  0 = average, 1 = max; sampled at start.
- kernel_sel  in  2  0→K=1, 1→K=2, 2→K=4, 3→K=1; sampled at start.
- num_out_rows  in  ROWS_W  output rows in the job; sampled at start; 0 treated as 1.
- in_valid  in  1  input row valid.
- in_ready  out  1  block accepts a row.
- in_data  in  LANES*DWIDTH  row vector; lane i at [i*DWIDTH +: DWIDTH].
- in_mask  in  LANES  1 = lane valid; a masked lane contributes 0.
- out_valid  out  1  result row valid.
- out_ready  in  1  downstream accepts.
- out_data  out  LANES*DWIDTH  result lanes 0..LANES/K-1; upper lanes 0.
- out_mask  out  LANES  lanes 0..LANES/K-1 set; others 0.
- done_pool  out  1  one-cycle pulse at job end.

## Operation
- **States:** IDLE, ACCUM, EMIT, DONE.
- **IDLE:**
  - in_ready=0.
  - start with enable_pool=1 → ACCUM.
  - mode, K and row count are latched; accumulators and the row counter are cleared.
- **ACCUM:**
  - in_ready=1.
  - Each accepted row (in_valid&&in_ready) folds into per-window accumulators. Window j covers lanes j*K..j*K+K-1.
  - After the K-th accepted row → EMIT.
- **Average mode:**
  - Accumulator is DWIDTH+4 bits wide, which fits 16 terms.
  - Result = sum >> (2·log2K), truncated. The divisor is K², regardless of mask.
- **Max mode:**
  - Running unsigned max. Masked lanes read as 0.
  - Accumulator initialised to 0 at the start of each window row group.
- **K=1:** each row is passed through with the mask applied; one output per input row.
- **EMIT:**
  - Result register holds out_valid=1 until out_ready.
  - On acceptance: the output-row count decrements. Count remaining → ACCUM with accumulators cleared; count exhausted → DONE.
- **DONE:** done_pool=1 for one cycle → IDLE.
- **Bypass (enable_pool=0):**
  - out_data=in_data, out_mask=in_mask, out_valid=in_valid, in_ready=out_ready. This is combinational.
  - done_pool=0.
  - The FSM is forced to IDLE on the next clock, discarding partial windows.
- **Other rules:**
  - start outside IDLE is ignored.
  - Mode and kernel inputs changing mid-job have no effect.

## Timing
- **Reset:**
  - State IDLE.
  - in_ready=0, out_valid=0, out_data=0, out_mask=0, done_pool=0.
  - Accumulators and counters 0.
  - Reset mid-job aborts immediately; no output is produced.
- **Latency:** out_valid rises on the cycle after the K-th row is accepted.
- **Throughput:** in_ready=0 during EMIT, so the block consumes at most K rows per K+1 cycles with out_ready held high.
- **Output stability:** out_data and out_mask are registered and stable while out_valid=1 and out_ready=0.
- **done_pool:** asserts the cycle after the final output handshake.
- **Simultaneous events:**
  - start together with enable_pool falling: start is ignored.
  - in_valid during EMIT: the row is not accepted and is held by the producer.

## Structure
- **Shared package (pool_pkg):**
  - State encoding.
  - kernel_sel encodings.
  - Mode constants.
  - Function log2K(kernel_sel).
- **Sub-module pool_window_reduce (parameterised on DWIDTH):**
  - Holds one window's accumulator.
  - Inputs: K lane values, mask bits, clear, accumulate, mode, K.
  - Outputs: the finished average or max.
  - Instantiated LANES times. Windows j ≥ LANES/K are unused and forced to 0.

## Test plan
- **K=2 average:** row 1 all lanes = 10, row 2 all lanes = 20, out_ready=1 → one output, lanes 0..7 = 15, lanes 8..15 = 0, out_mask=0x00FF, out_valid one cycle after row 2, done_pool one cycle later.
- **K=4 max:** 4 rows with lane value = row·16 + lane; lane 5 of row 3 = 255 → lane 0 = 51, lane 1 = 255, lane 2 = 59, lane 3 = 63; out_mask=0x000F.
- **Masking:** K=2 average, in_mask=0xFFFE, all values 40 → lane 0 = 30, other lanes 40.
- **Back-pressure:** num_out_rows=2 with out_ready=0 for 5 cycles in EMIT → out_data stable, in_ready=0, no row lost, done_pool only after the second handshake.
- **Bypass and abort:** enable_pool dropped after 1 of 4 rows (K=4) → combinational passthrough. Re-enable and start → fresh result, with no residue from the aborted row.
- **Async reset mid-EMIT:** assert reset → all outputs 0 immediately; after release, state is IDLE.
